// File: rtl/lcd_pkg.sv
// Shared LCD definitions: arbiter FSM state type and the serial LCD command
// bytes that the message generators emit ahead of their arguments.
package lcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [7:0] LCD_CMD_PREFIX = 8'hFE;
  localparam logic [7:0] LCD_CMD_CLEAR  = 8'h01;
  localparam logic [7:0] LCD_CMD_LINE2  = 8'hC0;

endpackage

// File: rtl/lcd_rr_pick.sv
// Rotate-priority picker: returns the first asserted valid strictly after
// ptr_i, wrapping modulo N, as a one-hot vector plus an any-valid flag.
module lcd_rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic          any_o
);

  logic [PW-1:0] idx_s;

  // Walk N positions starting one past the pointer; first hit wins.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx_s   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx_s = PW'((32'(ptr_i) + k) % N);
      if (!any_o && valid_i[idx_s]) begin
        grant_o[idx_s] = 1'b1;
        any_o          = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/lcd_fifo_arbiter.sv
// Message-granular round-robin arbiter for the LCD transmit FIFO write port.
// A grant is held for a whole message (until the holder's req_last byte is
// written) so multi-byte command sequences are never interleaved.
// Optional feature: define LCD_ARB_TIMEOUT_EN to revoke a grant whose holder
// leaves valid low for TIMEOUT cycles (abort pulses when that happens).
module lcd_fifo_arbiter
  import lcd_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        data,
  output logic              wrreq,
  input  logic              wrfull,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              abort
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            busy_q;
  logic            abort_q, abort_d;

  logic [NREQ-1:0] pick_grant_s;
  logic            pick_any_s;
  logic            hold_valid_s;
  logic            hold_last_s;
  logic [7:0]      hold_data_s;
  logic [PW-1:0]   hold_idx_s;
  logic            xfer_s;

`ifdef LCD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic [31:0] timeout_unused_s;
  assign timeout_unused_s = 32'(TIMEOUT);
`endif

  lcd_rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant_s),
    .any_o   (pick_any_s)
  );

  // Decode the current holder: its valid/last flags, data byte and index.
  always_comb begin
    hold_valid_s = |(req_valid & grant_q);
    hold_last_s  = |(req_last & grant_q);
    hold_data_s  = 8'h00;
    hold_idx_s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        hold_data_s = req_data[8*i +: 8];
        hold_idx_s  = PW'(i);
      end else begin
        hold_idx_s = hold_idx_s;
      end
    end
  end

  // A byte moves only in GRANT with the holder valid, FIFO room, not in reset.
  assign xfer_s    = (state_q == GRANT) & hold_valid_s & ~wrfull & ~rst;
  assign wrreq     = xfer_s;
  assign req_ready = xfer_s ? grant_q : '0;
  assign data      = xfer_s ? hold_data_s : 8'h00;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign abort     = abort_q;

  // Next-state logic: pick in IDLE, release on last byte (or on timeout).
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    abort_d = 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d = GRANT;
          grant_d = pick_grant_s;
        end else begin
          grant_d = '0;
        end
      end
      GRANT: begin
        if (xfer_s && hold_last_s) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = hold_idx_s;
`ifdef LCD_ARB_TIMEOUT_EN
          cnt_d   = '0;
        end else if (xfer_s) begin
          cnt_d = '0;
        end else if (!hold_valid_s) begin
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = hold_idx_s;
            abort_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`endif
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, pointer and registered status outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(NREQ - 1);
      busy_q  <= 1'b0;
      abort_q <= 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      busy_q  <= |grant_d;
      abort_q <= abort_d;
`ifdef LCD_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule
